// File: rtl/er_irq_dma_monitor.sv
`default_nettype none
// ============================================================================
// Module      : er_irq_dma_monitor
// Description : Executable-region (ER) monitor. Raises exec only while the
//               ER has been entered at ER_min and not disturbed by DMA,
//               an interrupt, or an invalid bound configuration. Also
//               reports the source of the most recent abort and a
//               saturating abort count.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk       in   1             system clock, rising edge
//   reset     in   1             synchronous active-high reset
//   pc        in   ADDR_W        current program counter
//   irq       in   1             interrupt taken this cycle
//   dma_en    in   N_DMA         per-channel DMA access active
//   dma_addr  in   N_DMA*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
//   ER_min    in   ADDR_W        first ER address (entry point)
//   ER_max    in   ADDR_W        last ER address (exit point)
//   exec      out  1             valid uninterrupted ER execution
//   viol_src  out  N_DMA+1       bit i = DMA ch i, MSB = irq (last abort)
//   viol_cnt  out  VCNT_W        aborts since reset, saturating
// Configuration macro
//   ER_IRQ_ABORT_EN : when defined, an irq while pc is inside the ER is a
//                     violation; when undefined, irq is ignored.
// ============================================================================
module er_irq_dma_monitor #(
  parameter int ADDR_W = 16,
  parameter int N_DMA  = 2,
  parameter int VCNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       pc,
  input  logic                    irq,
  input  logic [N_DMA-1:0]        dma_en,
  input  logic [N_DMA*ADDR_W-1:0] dma_addr,
  input  logic [ADDR_W-1:0]       ER_min,
  input  logic [ADDR_W-1:0]       ER_max,
  output logic                    exec,
  output logic [N_DMA:0]          viol_src,
  output logic [VCNT_W-1:0]       viol_cnt
);

  typedef enum logic [1:0] {
    ST_ABORT = 2'b00,
    ST_EXEC  = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_prev_max;   // previous cycle was a clean pc==ER_max
  logic             w_cfg_ok;
  logic             w_pc_in;
  logic             w_at_min;
  logic             w_at_max;
  logic [N_DMA-1:0] w_dma_v;
  logic             w_irq_v;
  logic             w_viol;

  assign w_cfg_ok = (ER_min <= ER_max);
  assign w_pc_in  = (pc >= ER_min) && (pc <= ER_max);
  assign w_at_min = (pc == ER_min);
  assign w_at_max = (pc == ER_max);

  // A channel is a violation if it is active while code runs in the ER,
  // or if it touches the ER regardless of where the pc is.
  for (genvar i = 0; i < N_DMA; i++) begin : g_dma
    logic [ADDR_W-1:0] w_addr;
    assign w_addr     = dma_addr[i*ADDR_W +: ADDR_W];
    assign w_dma_v[i] = dma_en[i] &&
                        (w_pc_in || ((w_addr >= ER_min) && (w_addr <= ER_max)));
  end

`ifdef ER_IRQ_ABORT_EN
  assign w_irq_v = irq && w_pc_in;
`else
  logic w_unused_irq;
  assign w_unused_irq = irq;
  assign w_irq_v      = 1'b0;
`endif

  assign w_viol = (|w_dma_v) || w_irq_v || !w_cfg_ok;

  // Violation always wins over entry at ER_min.
  always_comb begin
    w_next = ST_ABORT;
    case (r_state)
      ST_ABORT: w_next = (w_at_min && !w_viol) ? ST_EXEC : ST_ABORT;
      ST_EXEC: begin
        if (w_viol)                       w_next = ST_ABORT;
        else if (r_prev_max && !w_pc_in)  w_next = ST_DONE;
        else                              w_next = ST_EXEC;
      end
      ST_DONE: begin
        if (w_viol)                       w_next = ST_ABORT;
        else if (w_pc_in && !w_at_min)    w_next = ST_ABORT;
        else if (w_at_min)                w_next = ST_EXEC;
        else                              w_next = ST_DONE;
      end
      default:                            w_next = ST_ABORT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ABORT;
      r_prev_max <= 1'b0;
      exec       <= 1'b0;
      viol_src   <= '0;
      viol_cnt   <= '0;
    end else begin
      r_state    <= w_next;
      r_prev_max <= w_at_max && !w_viol;
      exec       <= (w_next != ST_ABORT);

      if (r_state != ST_ABORT && w_next == ST_ABORT)
        viol_src <= {w_irq_v, w_dma_v};
      else if (r_state == ST_ABORT && w_next == ST_EXEC)
        viol_src <= '0;

      if ((r_state == ST_EXEC || r_state == ST_DONE) && w_next == ST_ABORT &&
          viol_cnt != {VCNT_W{1'b1}})
        viol_cnt <= viol_cnt + VCNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_er_irq_dma_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_er_irq_dma_monitor
// Description : Directed, table-driven self-checking bench for
//               er_irq_dma_monitor (ADDR_W=16, N_DMA=2, VCNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_er_irq_dma_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        irq;
  logic [1:0]  dma_en;
  logic [31:0] dma_addr;
  logic [15:0] ER_min;
  logic [15:0] ER_max;
  logic        exec;
  logic [2:0]  viol_src;
  logic [7:0]  viol_cnt;

  int errors = 0;
  int checks = 0;

`ifdef ER_IRQ_ABORT_EN
  localparam int IRQ_AB = 1;
`else
  localparam int IRQ_AB = 0;
`endif

  er_irq_dma_monitor #(.ADDR_W(16), .N_DMA(2), .VCNT_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .pc       (pc),
    .irq      (irq),
    .dma_en   (dma_en),
    .dma_addr (dma_addr),
    .ER_min   (ER_min),
    .ER_max   (ER_max),
    .exec     (exec),
    .viol_src (viol_src),
    .viol_cnt (viol_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pc;
    logic        irq;
    logic [1:0]  en;
    logic [15:0] a1;
    logic [15:0] a0;
    logic [15:0] mn;
    logic [15:0] mx;
    logic        e_exec;
    logic [2:0]  e_src;
    logic [7:0]  e_cnt;
  } vec_t;

  vec_t vecs[29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic [1:0] en, input logic [15:0] a0);
    pc = p; irq = 1'b0; dma_en = en; dma_addr = {16'h0000, a0};
    ER_min = 16'hE000; ER_max = 16'hE0FF;
  endtask

  function automatic vec_t mk(input logic [15:0] p, input logic i, input logic [1:0] en,
                              input logic [15:0] a1, input logic [15:0] a0,
                              input logic [15:0] mn, input logic [15:0] mx,
                              input logic ex, input logic [2:0] src, input int cnt);
    vec_t v;
    v.pc = p; v.irq = i; v.en = en; v.a1 = a1; v.a0 = a0; v.mn = mn; v.mx = mx;
    v.e_exec = ex; v.e_src = src; v.e_cnt = 8'(cnt);
    return v;
  endfunction

  initial begin
    logic [15:0] N = 16'hE000;
    logic [15:0] X = 16'hE0FF;

    // pc            irq  en     a1       a0       min      max    exec src     cnt
    vecs[0]  = mk(16'hC000, 0, 2'b00, 16'h0, 16'h0, N, X, 0, 3'b000, 0);
    vecs[1]  = mk(16'hE000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 0);
    vecs[2]  = mk(16'hE002, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 0);
    vecs[3]  = mk(16'hE0FF, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 0);
    vecs[4]  = mk(16'hC010, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 0);  // DONE
    vecs[5]  = mk(16'hC011, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 0);
    vecs[6]  = mk(16'hE000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 0);  // re-run
    vecs[7]  = mk(16'hE010, 0, 2'b10, 16'h0200, 16'h0, N, X, 0, 3'b010, 1);
    vecs[8]  = mk(16'hE000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 1);
    vecs[9]  = mk(16'hE0FF, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 1);
    vecs[10] = mk(16'hC020, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 1);
    vecs[11] = mk(16'hC020, 0, 2'b01, 16'h0, 16'hE050, N, X, 0, 3'b001, 2);
    vecs[12] = mk(16'hE000, 0, 2'b01, 16'h0, 16'h0000, N, X, 0, 3'b001, 2); // entry+viol
    vecs[13] = mk(16'hC000, 0, 2'b01, 16'h0, 16'hE0FF, N, X, 0, 3'b001, 2); // viol in ABORT
    vecs[14] = mk(16'hE000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 2);
    vecs[15] = mk(16'hE0FF, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 2);
    vecs[16] = mk(16'hC000, 0, 2'b10, 16'hE000, 16'h0, N, X, 0, 3'b010, 3); // DMA at ER_min
    vecs[17] = mk(16'hE000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 3);
    vecs[18] = (IRQ_AB != 0) ? mk(16'hE020, 1, 2'b00, 16'h0, 16'h0, N, X, 0, 3'b100, 4)
                             : mk(16'hE020, 1, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 3);
    vecs[19] = mk(16'hE000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 3 + IRQ_AB);
    vecs[20] = mk(16'hE0FF, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 3 + IRQ_AB);
    vecs[21] = mk(16'hC000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 3 + IRQ_AB);
    vecs[22] = mk(16'hE080, 0, 2'b00, 16'h0, 16'h0, N, X, 0, 3'b000, 4 + IRQ_AB); // mid jump
    vecs[23] = mk(16'hE000, 0, 2'b00, 16'h0, 16'h0, N, X, 1, 3'b000, 4 + IRQ_AB);
    vecs[24] = mk(16'hE001, 0, 2'b00, 16'h0, 16'h0, 16'hE100, 16'hE0FF, 0, 3'b000, 5 + IRQ_AB);
    vecs[25] = mk(16'hD000, 0, 2'b00, 16'h0, 16'h0, 16'hD000, 16'hD000, 1, 3'b000, 5 + IRQ_AB);
    vecs[26] = mk(16'hD000, 0, 2'b00, 16'h0, 16'h0, 16'hD000, 16'hD000, 1, 3'b000, 5 + IRQ_AB);
    vecs[27] = mk(16'hD001, 0, 2'b00, 16'h0, 16'h0, 16'hD000, 16'hD000, 1, 3'b000, 5 + IRQ_AB);
    vecs[28] = mk(16'hD000, 0, 2'b00, 16'h0, 16'h0, 16'hD000, 16'hD000, 1, 3'b000, 5 + IRQ_AB);

    // Reset, held for two cycles.
    drive(16'hC000, 2'b00, 16'h0);
    reset = 1'b1;
    step();
    step();
    chk("reset_exec", 32'(exec), 32'd0);
    chk("reset_src",  32'(viol_src), 32'd0);
    chk("reset_cnt",  32'(viol_cnt), 32'd0);
    reset = 1'b0;

    for (int k = 0; k < 29; k++) begin
      pc = vecs[k].pc; irq = vecs[k].irq; dma_en = vecs[k].en;
      dma_addr = {vecs[k].a1, vecs[k].a0};
      ER_min = vecs[k].mn; ER_max = vecs[k].mx;
      step();
      chk($sformatf("v%0d_exec", k), 32'(exec), 32'(vecs[k].e_exec));
      chk($sformatf("v%0d_src", k),  32'(viol_src), 32'(vecs[k].e_src));
      chk($sformatf("v%0d_cnt", k),  32'(viol_cnt), 32'(vecs[k].e_cnt));
    end

    // Saturation: 2^8+2 entry/abort pairs.
    for (int k = 0; k < 258; k++) begin
      drive(16'hE000, 2'b00, 16'h0);
      step();
      drive(16'hE010, 2'b01, 16'h0100);
      step();
    end
    chk("sat_cnt",  32'(viol_cnt), 32'hFF);
    chk("sat_exec", 32'(exec), 32'd0);
    chk("sat_src",  32'(viol_src), 32'b001);
    // One more abort must not wrap.
    drive(16'hE000, 2'b00, 16'h0);
    step();
    drive(16'hE010, 2'b10, 16'h0);
    step();
    chk("sat_hold", 32'(viol_cnt), 32'hFF);

    // Reset in the middle of a run discards all history.
    drive(16'hE000, 2'b00, 16'h0);
    step();
    chk("pre_rst_exec", 32'(exec), 32'd1);
    drive(16'hE002, 2'b00, 16'h0);
    reset = 1'b1;
    step();
    chk("mid_rst_exec", 32'(exec), 32'd0);
    chk("mid_rst_cnt",  32'(viol_cnt), 32'd0);
    chk("mid_rst_src",  32'(viol_src), 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_exec", 32'(exec), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
